// File: rtl/counter_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// counter_seq_ctrl_if
//   Bundles the key, tick, switch and counter-side signals of the run-control
//   sequencer.
//
//   Signals:
//     PR       raw pause/resume button (active high, asynchronous)
//     tick     one-cycle 1 Hz pulse
//     max_CNT  target count from the switches
//     CNT_out  current counter value fed back from the counter
//     cnt_en   counter increment enable (combinational)
//     cnt_clr  synchronous counter clear pulse (registered)
//     done     target-reached pulse (registered)
//     state    current FSM state for LEDs
//
//   Modports:
//     master  the environment: drives keys, tick, switches and counter value
//     slave   the sequencer: consumes those and drives the control outputs
// ----------------------------------------------------------------------------
interface counter_seq_ctrl_if;
    logic       PR;
    logic       tick;
    logic [5:0] max_CNT;
    logic [5:0] CNT_out;
    logic       cnt_en;
    logic       cnt_clr;
    logic       done;
    logic [1:0] state;

    modport master (
        output PR,
        output tick,
        output max_CNT,
        output CNT_out,
        input  cnt_en,
        input  cnt_clr,
        input  done,
        input  state
    );

    modport slave (
        input  PR,
        input  tick,
        input  max_CNT,
        input  CNT_out,
        output cnt_en,
        output cnt_clr,
        output done,
        output state
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// ----------------------------------------------------------------------------
// counter_seq_ctrl
//   Run-control sequencer for the 6-bit up-counter. Turns a raw pause/resume
//   button and a 1 Hz tick into an IDLE/RUN/PAUSE/DONE state machine, issues
//   the count enable and a counter clear, and stops the count at a target
//   latched when the run starts.
//
//   Parameters:
//     SYNC_STAGES  synchronizer depth on PR (2 or 3)
//
//   Ports:
//     CLOCK_50  in   system clock, rising edge
//     RST       in   synchronous active-high reset
//     bus       slave modport of counter_seq_ctrl_if:
//                 PR, tick, max_CNT, CNT_out in;
//                 cnt_en (Mealy), cnt_clr, done, state out
// ----------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic               CLOCK_50,
    input logic               RST,
    counter_seq_ctrl_if.slave bus
);

    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StRun   = 2'b01;
    localparam logic [1:0] StPause = 2'b10;
    localparam logic [1:0] StDone  = 2'b11;

    // ------------------------------------------------------------------------
    // Button synchronizer and rising-edge detect.
    // Everything resets to 1 so a button held across reset release looks
    // like "already pressed" and produces no event until released.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_last;
    logic                   press;

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.PR};
            prev_q <= sync_last;
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign press     = sync_last & ~prev_q;

    // ------------------------------------------------------------------------
    // State, latched target and registered pulses
    // ------------------------------------------------------------------------
    logic [1:0] state_q,   state_d;
    logic [5:0] max_lat_q, max_lat_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic       done_q,    done_d;
    logic       reached;

    // >= rather than == so a counter that wrapped or started above the
    // target still terminates the run.
    assign reached = (bus.CNT_out >= max_lat_q);

    always_comb begin
        state_d   = state_q;
        max_lat_d = max_lat_q;
        cnt_clr_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (press) begin
                    // Target is sampled only here; switch changes during a
                    // run are ignored.
                    max_lat_d = bus.max_CNT;
                    cnt_clr_d = 1'b1;
                    if (bus.max_CNT == 6'd0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Press wins over reaching the target.
                if (press) begin
                    state_d = StPause;
                end else if (reached) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StPause: begin
                // Resume keeps the held count; no clear.
                if (press) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                if (press) begin
                    state_d   = StIdle;
                    cnt_clr_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state_q   <= StIdle;
            max_lat_q <= 6'd0;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_lat_q <= max_lat_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The clear cycle is masked so a tick landing there cannot race the clear
    // in the counter; press and reached mask the tick so the count freezes
    // at its pre-press value and never overshoots the target.
    assign bus.cnt_en  = (state_q == StRun) & bus.tick & ~press & ~reached & ~cnt_clr_q;
    assign bus.cnt_clr = cnt_clr_q;
    assign bus.done    = done_q;
    assign bus.state   = state_q;

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
    a_en_only_in_run : assert property (@(posedge CLOCK_50) disable iff (RST)
        bus.cnt_en |-> (state_q == StRun));
    a_no_en_on_clr : assert property (@(posedge CLOCK_50) disable iff (RST)
        cnt_clr_q |-> !bus.cnt_en);
    a_done_in_done : assert property (@(posedge CLOCK_50) disable iff (RST)
        done_q |-> (state_q == StDone));

endmodule
